// File: rtl/cla_add16_pipe_if.sv
// cla_add16_pipe_if: operand/result valid-ready bundle for cla_add16_pipe.
// ovf exists only when CLA_ADD16_PIPE_OVF_EN is defined.
interface cla_add16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        grp_gg;
  logic        grp_gp;
`ifdef CLA_ADD16_PIPE_OVF_EN
  logic        ovf;
`endif
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, grp_gg, grp_gp
`ifdef CLA_ADD16_PIPE_OVF_EN
    , input ovf
`endif
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, grp_gg, grp_gp
`ifdef CLA_ADD16_PIPE_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/cla_add16_pipe.sv
// cla_add16_pipe: 2-stage 16-bit carry-lookahead adder (S1 G/P, S2 lookahead+sum) with valid/ready flow.
// Define CLA_ADD16_PIPE_OVF_EN to add the registered signed-overflow output ovf.
module cla_add16_pipe (
  input logic clk,
  input logic rst_n,
  cla_add16_pipe_if.slave bus
);
  function automatic logic grp_g(input logic [3:0] g, input logic [3:0] p);
    return g[3] | p[3] & g[2] | p[3] & p[2] & g[1] | p[3] & p[2] & p[1] & g[0];
  endfunction
  // carries into bits 0..3 of a 4-bit group from its g/p and carry-in
  function automatic logic [3:0] cla_c(input logic [3:0] g, input logic [3:0] p, input logic ci);
    return {g[2] | p[2] & g[1] | p[2] & p[1] & g[0] | p[2] & p[1] & p[0] & ci,
            g[1] | p[1] & g[0] | p[1] & p[0] & ci,
            g[0] | p[0] & ci,
            ci};
  endfunction
  logic        v1, v2, c1, adv1, adv2;
  logic [15:0] gi, pi, g1, p1, c, s;
  logic [3:0]  gk_in, pk_in, gk1, pk1, gc;
  assign gi = bus.a & bus.b;
  assign pi = bus.a ^ bus.b;
  for (genvar k = 0; k < 4; k++) begin : grp
    assign gk_in[k] = grp_g(gi[4*k +: 4], pi[4*k +: 4]);
    assign pk_in[k] = &pi[4*k +: 4];
    assign c[4*k +: 4] = cla_c(g1[4*k +: 4], p1[4*k +: 4], gc[k]);
  end
  // second level reuses the same lookahead over group G/P
  assign gc = cla_c(gk1, pk1, c1);
  assign s = p1 ^ c;
  assign adv2 = ~v2 | bus.out_ready;
  assign adv1 = ~v1 | adv2;
  assign bus.in_ready = adv1;
  assign bus.out_valid = v2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1  <= 1'b0;
      c1  <= 1'b0;
      g1  <= '0;
      p1  <= '0;
      gk1 <= '0;
      pk1 <= '0;
    end else if (adv1) begin
      v1  <= bus.in_valid;
      c1  <= bus.cin;
      g1  <= gi;
      p1  <= pi;
      gk1 <= gk_in;
      pk1 <= pk_in;
    end
  // with p15=0 the operands share bit 15, which equals g15
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2         <= 1'b0;
      bus.sum    <= '0;
      bus.cout   <= 1'b0;
      bus.grp_gg <= 1'b0;
      bus.grp_gp <= 1'b0;
`ifdef CLA_ADD16_PIPE_OVF_EN
      bus.ovf    <= 1'b0;
`endif
    end else if (adv2) begin
      v2         <= v1;
      bus.sum    <= s;
      bus.cout   <= gk1[3] | pk1[3] & gc[3];
      bus.grp_gg <= grp_g(gk1, pk1);
      bus.grp_gp <= &pk1;
`ifdef CLA_ADD16_PIPE_OVF_EN
      bus.ovf    <= ~p1[15] & (s[15] ^ g1[15]);
`endif
    end
endmodule
